// File: rtl/full_adder.sv
// full_adder: unsigned WIDTH-bit ripple-carry adder producing {carry, sum}
// = a + b + cin. With OUT_REG = 1 the result is registered (one cycle of
// latency, asynchronous active-low clear); with OUT_REG = 0 the result is
// purely combinational and clk/rst_n are ignored.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // Sum output of a single 1-bit full-adder cell.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // Carry output of a single 1-bit full-adder cell: generate, or propagate
    // an incoming carry.
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (ci & (x ^ y));
    endfunction

    // w_c[i] is the carry into bit i; w_c[WIDTH] is the final carry-out.
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum_p0;

    assign w_c[0] = cin;

    // Ripple chain: each cell's carry-out feeds the next cell's carry-in.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_sum_p0[i] = fa_sum(a[i], b[i], w_c[i]);
        assign w_c[i+1]    = fa_carry(a[i], b[i], w_c[i]);
    end

    // ---- stage boundary: optional output register ----
    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] r_sum_p1;
        logic             r_carry_p1;

        // Load a fresh result every edge; reset clears it immediately and
        // throws away whatever was in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum_p1   <= '0;
                r_carry_p1 <= 1'b0;
            end else begin
                r_sum_p1   <= w_sum_p0;
                r_carry_p1 <= w_c[WIDTH];
            end
        end

        assign sum   = r_sum_p1;
        assign carry = r_carry_p1;
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk & rst_n;

        assign sum   = w_sum_p0;
        assign carry = w_c[WIDTH];
    end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: table-driven and scoreboard-checked bench covering a 1-bit
// registered adder, an 8-bit registered adder and a 1-bit combinational adder.
module tb_full_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] res;   // expected {carry, sum}
    } vec_t;

    typedef struct {
        logic [8:0] res;
        int         idx;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic sum1, carry1;
    logic [7:0] a8 = '0, b8 = '0;
    logic cin8 = 1'b0;
    logic [7:0] sum8;
    logic carry8;
    logic ac = 1'b0, bc = 1'b0, cinc = 1'b0;
    logic sumc, carryc;

    int n_cmp = 0;
    int n_err = 0;

    sb_t q1[$];
    sb_t q8[$];

    vec_t tv1[8];
    vec_t tv8[8];

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .OUT_REG(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .carry(carry1)
    );

    full_adder #(.WIDTH(8), .OUT_REG(1'b1)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .carry(carry8)
    );

    full_adder #(.WIDTH(1), .OUT_REG(1'b0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .a(ac), .b(bc), .cin(cinc),
        .sum(sumc), .carry(carryc)
    );

    task automatic chk(input string name, input int idx,
                       input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got {carry,sum}=%h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic pop1(input string name);
        sb_t e;
        if (q1.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", name, {7'd0, carry1, sum1});
        end else begin
            e = q1.pop_front();
            chk(name, e.idx, {7'd0, carry1, sum1}, e.res);
        end
    endtask

    task automatic pop8(input string name);
        sb_t e;
        if (q8.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", name, {carry8, sum8});
        end else begin
            e = q8.pop_front();
            chk(name, e.idx, {carry8, sum8}, e.res);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] ref9;
        // 1-bit truth table, expected {carry,sum} written out by hand.
        tv1[0] = '{8'd0, 8'd0, 1'b0, 9'b0_0000_0000};
        tv1[1] = '{8'd0, 8'd0, 1'b1, 9'b0_0000_0001};
        tv1[2] = '{8'd0, 8'd1, 1'b0, 9'b0_0000_0001};
        tv1[3] = '{8'd0, 8'd1, 1'b1, 9'b0_0000_0010};
        tv1[4] = '{8'd1, 8'd0, 1'b0, 9'b0_0000_0001};
        tv1[5] = '{8'd1, 8'd0, 1'b1, 9'b0_0000_0010};
        tv1[6] = '{8'd1, 8'd1, 1'b0, 9'b0_0000_0010};
        tv1[7] = '{8'd1, 8'd1, 1'b1, 9'b0_0000_0011};
        // 8-bit directed vectors.
        tv8[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        tv8[1] = '{8'h7F, 8'h80, 1'b1, 9'h100};
        tv8[2] = '{8'h12, 8'h34, 1'b0, 9'h046};
        tv8[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
        tv8[4] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        tv8[5] = '{8'hFF, 8'h00, 1'b1, 9'h100};
        tv8[6] = '{8'hAA, 8'h55, 1'b0, 9'h0FF};
        tv8[7] = '{8'h80, 8'h80, 1'b0, 9'h100};

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1 chk("reset_async_w1", 0, {7'd0, carry1, sum1}, 9'd0);
        chk("reset_async_w8", 0, {carry8, sum8}, 9'd0);

        // Held in reset across edges with all-ones inputs.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hold_w1", 0, {7'd0, carry1, sum1}, 9'd0);

        // Release; the first edge must load the inputs present then (1+1+1).
        rst_n = 1'b1;
        q1.push_back('{9'b11, 100});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pop1("truth_w1");
            a1 = tv1[i].a[0]; b1 = tv1[i].b[0]; cin1 = tv1[i].cin;
            q1.push_back('{tv1[i].res, i});
        end
        @(negedge clk);
        pop1("truth_w1");

        // Inputs changing between edges must not reach the outputs early.
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        chk("hold_pre_w1", 0, {7'd0, carry1, sum1}, 9'd0);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        #2 chk("hold_mid_w1", 0, {7'd0, carry1, sum1}, 9'd0);
        @(posedge clk);
        #1 chk("hold_post_w1", 0, {7'd0, carry1, sum1}, 9'b11);

        // Mid-cycle reset clears at once, discards the result, then recovers.
        #2 rst_n = 1'b0;
        #1 chk("midreset_clear_w1", 0, {7'd0, carry1, sum1}, 9'd0);
        @(posedge clk);
        #1 chk("midreset_hold_w1", 0, {7'd0, carry1, sum1}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("midreset_release_w1", 0, {7'd0, carry1, sum1}, 9'b11);

        // 8-bit: directed table then random vectors, modelled as a+b+cin.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (i > 0) pop8("add_w8");
            if (i < 8) begin
                a8 = tv8[i].a; b8 = tv8[i].b; cin8 = tv8[i].cin;
                q8.push_back('{tv8[i].res, i});
            end else begin
                a8 = 8'($urandom_range(0, 255));
                b8 = 8'($urandom_range(0, 255));
                cin8 = 1'($urandom_range(0, 1));
                ref9 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
                q8.push_back('{ref9, i});
            end
        end
        @(negedge clk);
        pop8("add_w8");

        // Combinational build: outputs follow inputs with no clock involved.
        for (int i = 0; i < 8; i++) begin
            ac = tv1[i].a[0]; bc = tv1[i].b[0]; cinc = tv1[i].cin;
            #1 chk("comb_w1", i, {7'd0, carryc, sumc}, tv1[i].res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits; WIDTH >= 1.
REQ-002 Parameter OUT_REG, default 1: 1 = registered outputs (latency 1 cycle); 0 = combinational outputs, registers bypassed.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  WIDTH  addend A, unsigned.
REQ-006 b  input  WIDTH  addend B, unsigned.
REQ-007 cin  input  1  carry-in.
REQ-008 sum  output  WIDTH  low WIDTH bits of a + b + cin.
REQ-009 carry  output  1  carry-out, bit WIDTH of a + b + cin.
REQ-010 The block SHALL have one clock and one reset: reset is asynchronous and active-low.

Function
REQ-011 The block SHALL compute the (WIDTH+1)-bit result a + b + cin, unsigned, with no overflow loss: {carry, sum}.
REQ-012 For WIDTH = 1, the block SHALL implement sum = a XOR b XOR cin.
REQ-013 For WIDTH = 1, the block SHALL implement carry = (a AND b) OR (cin AND (a XOR b)).
REQ-014 For WIDTH > 1, the block SHALL behave as a ripple of WIDTH 1-bit full-adder cells, bit i carry-out feeding bit i+1 carry-in, cin into bit 0, carry from bit WIDTH-1.
REQ-015 With OUT_REG = 1, the block SHALL capture {carry, sum} on each rising clk edge while rst_n is high; outputs reflect inputs sampled at the previous edge, latency exactly 1 cycle, throughput 1 result per cycle.
REQ-016 With OUT_REG = 1, input changes between clock edges SHALL NOT affect sum or carry until the next rising edge.
REQ-017 With OUT_REG = 0, sum and carry SHALL follow a, b and cin combinationally with zero cycle latency; clk and rst_n are then unused.
REQ-018 The block SHALL have no enable or handshake: every rising edge loads a new result.
REQ-019 Inputs equal to X/Z are out of scope; there is no defined output for them.
REQ-020 Wrap-around: when a + b + cin >= 2^WIDTH, the block SHALL assert carry = 1 and sum = (a + b + cin) - 2^WIDTH.

Reset
REQ-021 With OUT_REG = 1, assertion of rst_n low SHALL clear sum to 0 and carry to 0 immediately, independent of clk.
REQ-022 While rst_n is low, sum and carry SHALL remain 0 regardless of inputs or clock edges.
REQ-023 After rst_n deasserts, the first rising clk edge SHALL load the result of the inputs present at that edge.
REQ-024 Reset asserted mid-operation SHALL discard the pending registered result; there is no recovery of prior state.

Verification
REQ-025 WIDTH=1, OUT_REG=1: reset low -> sum=0, carry=0 asynchronously, before any clk edge.
REQ-026 WIDTH=1, OUT_REG=1: apply all 8 {a,b,cin} combinations 000..111, one per cycle -> one cycle later (sum,carry) = (0,0), (1,0), (1,0), (0,1), (1,0), (0,1), (0,1), (1,1).
REQ-027 WIDTH=1, OUT_REG=1: change inputs from 000 to 111 between edges -> outputs hold 0,0 until the next rising edge, then 1,1.
REQ-028 WIDTH=1, OUT_REG=1: drive a=1 b=1 cin=1, then pull rst_n low mid-cycle -> sum=0, carry=0 at once; release rst_n -> next edge gives sum=1, carry=1.
REQ-029 WIDTH=8, OUT_REG=1: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, carry=1; a=8'h7F, b=8'h80, cin=1 -> sum=8'h00, carry=1; a=8'h12, b=8'h34, cin=0 -> sum=8'h46, carry=0.
REQ-030 WIDTH=1, OUT_REG=0: apply the 8 input combinations with no clock -> outputs match the REQ-026 truth table immediately after each input change.
